arm_mc_control: RTL

ARM_MC_CONTROL -- requirements
Module: arm_mc_control

---
 rtl/arm_mc_pkg.sv | 62 ++++++
 rtl/arm_mc_condcheck.sv | 27 ++
 rtl/arm_mc_control.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/arm_mc_pkg.sv
// Shared encodings for the multi-cycle ARM control unit: FSM states, ALU
// controls, condition codes, instruction field values and datapath mux selects.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXECR  = 4'd2,
    S_EXECI  = 4'd3,
    S_ALUWB  = 4'd4,
    S_MEMADR = 4'd5,
    S_MEMRD  = 4'd6,
    S_MEMWB  = 4'd7,
    S_MEMWR  = 4'd8,
    S_BRANCH = 4'd9,
    S_BX     = 4'd10
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_ORR = 4'b1100;
  localparam logic [3:0] ALU_MOV = 4'b1101;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] DP_AND = 4'b0000;
  localparam logic [3:0] DP_SUB = 4'b0010;
  localparam logic [3:0] DP_ADD = 4'b0100;
  localparam logic [3:0] DP_CMP = 4'b1010;
  localparam logic [3:0] DP_ORR = 4'b1100;
  localparam logic [3:0] DP_MOV = 4'b1101;

  localparam logic [23:0] BX_PATTERN = 24'h12FFF1;

  localparam logic [1:0] SRCA_REG   = 2'b00;
  localparam logic [1:0] SRCA_PC    = 2'b01;
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  function automatic logic [3:0] alu_decode(input logic [3:0] opcode);
    case (opcode)
      DP_AND:  return ALU_AND;
      DP_SUB:  return ALU_SUB;
      DP_CMP:  return ALU_SUB;
      DP_ORR:  return ALU_ORR;
      DP_MOV:  return ALU_MOV;
      DP_ADD:  return ALU_ADD;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/arm_mc_condcheck.sv
// Z flag register and ARM condition evaluation (EQ/NE tested, all else passes).
import arm_mc_pkg::*;

module arm_mc_condcheck (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic       z_we,
  input  logic       zero_flag,
  output logic       cond_pass,
  output logic       z
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    z <= 1'b0;
    else if (z_we) z <= zero_flag;
  end

  always_comb begin
    case (cond)
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = !z;
      default: cond_pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/arm_mc_control.sv
// Multi-cycle ARM control FSM with memory-wait timeout (bus_err).
// Optional BX support is enabled by defining ARM_MC_BX_EN.
import arm_mc_pkg::*;

module arm_mc_control #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic        zero_flag,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [3:0]  ALUControl,
  output logic        bus_err,
  output logic [3:0]  state
);

  localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt;
  logic       in_wait, timeout, cond_pass, z, z_we;

  logic [1:0] op;
  logic [3:0] opcode, rd;
  logic       imm_i, s_bit, l_bit, link, is_cmp, is_bx, instr_unused;

  assign op           = Instr[27:26];
  assign imm_i        = Instr[25];
  assign opcode       = Instr[24:21];
  assign link         = Instr[24];
  assign s_bit        = Instr[20];
  assign l_bit        = Instr[20];
  assign rd           = Instr[15:12];
  assign is_cmp       = (opcode == DP_CMP);
  assign is_bx        = (Instr[27:4] == BX_PATTERN);
  assign instr_unused = ^Instr[3:0];

  assign ImmSrc = op;
  assign RegSrc = {op == OP_MEM, op == OP_BR};
  assign state  = state_q;

  arm_mc_condcheck u_cond (
    .clk       (clk),
    .reset     (reset),
    .cond      (Instr[31:28]),
    .z_we      (z_we),
    .zero_flag (zero_flag),
    .cond_pass (cond_pass),
    .z         (z)
  );

  assign z_we = (state_q == S_EXECR || state_q == S_EXECI) && (s_bit || is_cmp);

  // Counter holds the number of mem_ready-low cycles already spent in this
  // wait state; a ready in the cycle it equals WAIT_MAX still completes.
  assign in_wait = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign timeout = in_wait && !mem_ready && (wait_cnt == WAIT_MAX);
  assign bus_err = timeout && reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      wait_cnt <= 8'd0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= (in_wait && !mem_ready && !timeout) ? wait_cnt + 8'd1 : 8'd0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (!timeout && mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (!cond_pass) state_d = S_FETCH;
        // BX encoding lives in the DP opcode space, so it must be caught first
        else if (is_bx) begin
`ifdef ARM_MC_BX_EN
          state_d = S_BX;
`else
          state_d = S_FETCH;
`endif
        end else begin
          case (op)
            OP_DP:   state_d = imm_i ? S_EXECI : S_EXECR;
            OP_MEM:  state_d = S_MEMADR;
            OP_BR:   state_d = S_BRANCH;
            default: state_d = S_FETCH;
          endcase
        end
      end
      S_EXECR,
      S_EXECI:  state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_MEMADR: state_d = l_bit ? S_MEMRD : S_MEMWR;
      S_MEMRD:  begin
        if (timeout)        state_d = S_FETCH;
        else if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (timeout || mem_ready) state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
`ifdef ARM_MC_BX_EN
      S_BX:     state_d = S_FETCH;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = SRCA_REG;
    ALUSrcB    = SRCB_REG;
    ResultSrc  = RES_ALUOUT;
    ALUControl = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      S_EXECR:  ALUControl = alu_decode(opcode);
      S_EXECI: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = alu_decode(opcode);
      end
      S_ALUWB: begin
        RegWrite = !is_cmp;
        PCWrite  = !is_cmp && (rd == 4'd15);
      end
      S_MEMADR: ALUSrcB = SRCB_IMM;
      S_MEMRD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_MEM;
        RegWrite  = 1'b1;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = !timeout;
      end
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALU;
        PCWrite   = 1'b1;
        RegWrite  = link;
      end
`ifdef ARM_MC_BX_EN
      S_BX: begin
        ALUControl = ALU_MOV;
        ResultSrc  = RES_ALU;
        PCWrite    = 1'b1;
      end
`endif
      default: ;
    endcase
    // Reset kills any in-flight access combinationally, not at the next edge
    if (!reset) begin
      mem_req  = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
    end
  end

endmodule
